// File: rtl/score_keeper_if.sv
// Bus between collision/timing logic and the score keeper, plus the
// committed score/lives/state outputs feeding the renderer.
interface score_keeper_if;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       start;
  logic       hit;
  logic [3:0] points;
  logic       miss;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] lives;
  logic       playing;
  logic       game_over;

  modport master (
    output pixpulse, hcount, vcount, start, hit, points, miss,
    input  score, high_score, lives, playing, game_over
  );

  modport slave (
    input  pixpulse, hcount, vcount, start, hit, points, miss,
    output score, high_score, lives, playing, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// Game-state and score bookkeeping: accumulates hit/miss events during a
// frame and commits them to score/lives once per frame on the VTICK line.
module score_keeper #(
  parameter int VTICK       = 480,
  parameter int LIVES       = 3,
  parameter int OVER_FRAMES = 120
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  state_t     state;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] lives;
  logic       playing;
  logic       game_over;
  logic [7:0] pending_pts;
  logic [1:0] pending_miss;
  logic [7:0] over_cnt;

  logic       tick;
  logic [8:0] pts_sum;
  logic [7:0] pts_next;
  logic [1:0] miss_next;
  logic [8:0] score_sum;
  logic [7:0] score_new;
  logic [1:0] lives_new;

  assign tick = bus.pixpulse && (bus.hcount == 10'd0) && (bus.vcount == 10'(VTICK));

  assign pts_sum   = {1'b0, pending_pts} + {5'b0, bus.points};
  assign pts_next  = pts_sum[8] ? 8'hff : pts_sum[7:0];
  assign miss_next = (pending_miss == 2'd3) ? 2'd3 : pending_miss + 2'd1;
  assign score_sum = {1'b0, score} + {1'b0, pending_pts};
  assign score_new = score_sum[8] ? 8'hff : score_sum[7:0];
  assign lives_new = (pending_miss >= lives) ? 2'd0 : lives - pending_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      score        <= 8'd0;
      high_score   <= 8'd0;
      lives        <= 2'd0;
      playing      <= 1'b0;
      game_over    <= 1'b0;
      pending_pts  <= 8'd0;
      pending_miss <= 2'd0;
      over_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= PLAYING;
            playing      <= 1'b1;
            game_over    <= 1'b0;
            score        <= 8'd0;
            lives        <= 2'(LIVES);
            pending_pts  <= 8'd0;
            pending_miss <= 2'd0;
          end
        end
        PLAYING: begin
          if (tick) begin
            score <= score_new;
            lives <= lives_new;
            if (lives_new == 2'd0) begin
              state        <= OVER;
              playing      <= 1'b0;
              game_over    <= 1'b1;
              over_cnt     <= 8'd0;
              pending_pts  <= 8'd0;
              pending_miss <= 2'd0;
              if (score_new > high_score) high_score <= score_new;
            end else begin
              // events coincident with the tick belong to the next frame
              pending_pts  <= bus.hit  ? {4'd0, bus.points} : 8'd0;
              pending_miss <= bus.miss ? 2'd1 : 2'd0;
            end
          end else begin
            if (bus.hit)  pending_pts  <= pts_next;
            if (bus.miss) pending_miss <= miss_next;
          end
        end
        OVER: begin
          if (bus.start) begin
            state        <= PLAYING;
            playing      <= 1'b1;
            game_over    <= 1'b0;
            score        <= 8'd0;
            lives        <= 2'(LIVES);
            pending_pts  <= 8'd0;
            pending_miss <= 2'd0;
          end else if (tick) begin
            if (over_cnt == 8'(OVER_FRAMES - 1)) begin
              state     <= IDLE;
              game_over <= 1'b0;
            end else begin
              over_cnt <= over_cnt + 8'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score      = score;
  assign bus.high_score = high_score;
  assign bus.lives      = lives;
  assign bus.playing    = playing;
  assign bus.game_over  = game_over;
endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus a randomized run, all
// checked against a frame-level behavioural model.
module tb_score_keeper;
  localparam int VTICK       = 480;
  localparam int LIVES       = 3;
  localparam int OVER_FRAMES = 120;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  score_keeper_if bus();

  score_keeper #(.VTICK(VTICK), .LIVES(LIVES), .OVER_FRAMES(OVER_FRAMES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 playing, 2 over; frame totals kept unbounded
  int m_state, m_score, m_hs, m_lives, m_fpts, m_fmiss, m_oticks;

  function automatic logic [20:0] act();
    return {bus.score, bus.high_score, bus.lives, bus.playing, bus.game_over};
  endfunction

  function automatic logic [20:0] expv();
    return {8'(m_score), 8'(m_hs), 2'(m_lives), m_state == 1, m_state == 2};
  endfunction

  task automatic model(input bit r, s, h, input int p, input bit m, tk);
    if (r) begin
      m_state = 0; m_score = 0; m_hs = 0; m_lives = 0;
      m_fpts = 0; m_fmiss = 0; m_oticks = 0;
    end else if (m_state != 1 && s) begin
      m_state = 1; m_score = 0; m_lives = LIVES; m_fpts = 0; m_fmiss = 0;
    end else if (m_state == 1) begin
      if (tk) begin
        m_score = (m_score + m_fpts > 255) ? 255 : m_score + m_fpts;
        m_lives = (m_lives - m_fmiss < 0) ? 0 : m_lives - m_fmiss;
        m_fpts  = h ? p : 0;
        m_fmiss = m ? 1 : 0;
        if (m_lives == 0) begin
          m_state = 2; m_oticks = 0; m_fpts = 0; m_fmiss = 0;
          if (m_score > m_hs) m_hs = m_score;
        end
      end else begin
        if (h) m_fpts += p;
        if (m) m_fmiss++;
      end
    end else if (m_state == 2 && tk) begin
      m_oticks++;
      if (m_oticks == OVER_FRAMES) m_state = 0;
    end
  endtask

  task automatic step(input bit r, s, h, input logic [3:0] p, input bit m,
                      input bit pp, input logic [9:0] hc, vc);
    rst = r; bus.start = s; bus.hit = h; bus.points = p; bus.miss = m;
    bus.pixpulse = pp; bus.hcount = hc; bus.vcount = vc;
    @(posedge clk); #1;
    model(r, s, h, int'(p), m, pp && hc == 10'd0 && vc == 10'(VTICK));
  endtask

  task automatic ev(input bit h, input logic [3:0] p, input bit m);
    step(0, 0, h, p, m, 1'b1, 10'd17, 10'd100);
  endtask

  task automatic tk(input bit h, input logic [3:0] p, input bit m);
    step(0, 0, h, p, m, 1'b1, 10'd0, 10'(VTICK));
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    if (act() !== 21'd0) begin
      $display("FAIL reset: got %h want 0", act()); bad++;
    end
    total++;
    tk(0, 0, 0);
    if (act() !== expv()) begin
      $display("FAIL idle_tick: got %h want %h", act(), expv()); bad++;
    end
    total++;
  endtask

  task automatic test_basic();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) ev(1, 4'd5, 0);
    if ({bus.score, bus.lives, bus.playing} !== {8'd0, 2'd3, 1'b1}) begin
      $display("FAIL basic_pre: got %h want %h", {bus.score, bus.lives, bus.playing}, {8'd0, 2'd3, 1'b1}); bad++;
    end
    total++;
    tk(0, 0, 0);
    if ({bus.score, bus.lives, bus.playing} !== {8'd15, 2'd3, 1'b1}) begin
      $display("FAIL basic_commit: got %h want %h", {bus.score, bus.lives, bus.playing}, {8'd15, 2'd3, 1'b1}); bad++;
    end
    total++;
  endtask

  task automatic test_tick_hit();
    tk(1, 4'd7, 0);
    if (bus.score !== 8'd15) begin
      $display("FAIL tick_hit_same: got %0d want 15", bus.score); bad++;
    end
    total++;
    ev(0, 0, 0);
    tk(0, 0, 0);
    if (bus.score !== 8'd22) begin
      $display("FAIL tick_hit_next: got %0d want 22", bus.score); bad++;
    end
    total++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 15; i++) ev(1, 4'd15, 0);
    ev(1, 4'd3, 0);
    tk(0, 0, 0);
    if (bus.score !== 8'd250) begin
      $display("FAIL sat_250: got %0d want 250", bus.score); bad++;
    end
    total++;
    ev(1, 4'd5, 0);
    ev(1, 4'd7, 0);
    ev(1, 4'd0, 0);
    tk(0, 0, 0);
    if (bus.score !== 8'd255) begin
      $display("FAIL sat_255: got %0d want 255", bus.score); bad++;
    end
    total++;
    ev(1, 4'd9, 0);
    tk(0, 0, 0);
    if (bus.score !== 8'd255 || act() !== expv()) begin
      $display("FAIL sat_hold: got %h want %h", act(), expv()); bad++;
    end
    total++;
  endtask

  task automatic test_over();
    for (int i = 0; i < 4; i++) ev(0, 0, 1);
    if (bus.lives !== 2'd3) begin
      $display("FAIL over_pre: got lives %0d want 3", bus.lives); bad++;
    end
    total++;
    tk(0, 0, 0);
    if ({bus.lives, bus.game_over, bus.playing, bus.high_score} !== {2'd0, 1'b1, 1'b0, 8'd255}) begin
      $display("FAIL over_enter: got %h want %h", act(), expv()); bad++;
    end
    total++;
    // near-miss positions and ignored events must not advance anything
    ev(1, 4'd9, 1);
    step(0, 0, 0, 0, 0, 1'b0, 10'd0, 10'(VTICK));
    step(0, 0, 0, 0, 0, 1'b1, 10'd1, 10'(VTICK));
    step(0, 0, 0, 0, 0, 1'b1, 10'd0, 10'(VTICK + 1));
    for (int i = 0; i < OVER_FRAMES - 1; i++) begin
      tk(0, 0, 0);
      ev(0, 0, 0);
    end
    if (bus.game_over !== 1'b1 || act() !== expv()) begin
      $display("FAIL over_hold: got %h want %h", act(), expv()); bad++;
    end
    total++;
    tk(0, 0, 0);
    if ({bus.game_over, bus.playing, bus.score} !== {1'b0, 1'b0, 8'd255}) begin
      $display("FAIL over_exit: got %h want %h", act(), expv()); bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    ev(1, 4'd15, 0);
    ev(1, 4'd5, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    if (act() !== 21'd0) begin
      $display("FAIL reset_mid: got %h want 0", act()); bad++;
    end
    total++;
    tk(0, 0, 0);
    if (act() !== 21'd0) begin
      $display("FAIL reset_mid_tick: got %h want 0", act()); bad++;
    end
    total++;
  endtask

  task automatic test_start_tick();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    ev(1, 4'd15, 0);
    ev(1, 4'd15, 1);
    ev(0, 0, 1);
    ev(0, 0, 1);
    tk(0, 0, 0);
    if ({bus.score, bus.high_score, bus.game_over} !== {8'd30, 8'd30, 1'b1}) begin
      $display("FAIL hs_update: got %h want %h", act(), expv()); bad++;
    end
    total++;
    step(0, 1, 0, 0, 0, 1'b1, 10'd0, 10'(VTICK));
    if (act() !== {8'd0, 8'd30, 2'd3, 1'b1, 1'b0}) begin
      $display("FAIL start_tick: got %h want %h", act(), {8'd0, 8'd30, 2'd3, 1'b1, 1'b0}); bad++;
    end
    total++;
    ev(1, 4'd12, 0);
    ev(1, 4'd8, 1);
    ev(0, 0, 1);
    ev(0, 0, 1);
    tk(0, 0, 0);
    if (act() !== {8'd20, 8'd30, 2'd0, 1'b0, 1'b1}) begin
      $display("FAIL hs_keep: got %h want %h", act(), {8'd20, 8'd30, 2'd0, 1'b0, 1'b1}); bad++;
    end
    total++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      bit r, s, h, m, pp;
      logic [9:0] hc, vc;
      r  = ($urandom_range(499) == 0);
      s  = ($urandom_range(39) == 0);
      h  = ($urandom_range(3) == 0);
      m  = ($urandom_range(11) == 0);
      if ($urandom_range(14) == 0) begin
        pp = 1'b1; hc = 10'd0; vc = 10'(VTICK);
      end else begin
        pp = 1'($urandom); hc = 10'($urandom_range(2)); vc = 10'(VTICK - 1 + $urandom_range(2));
      end
      step(r, s, h, 4'($urandom), m, pp, hc, vc);
      if (act() !== expv()) begin
        $display("FAIL random[%0d]: got %h want %h", i, act(), expv()); bad++;
      end
      total++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.hit = 0; bus.points = 0; bus.miss = 0;
    bus.pixpulse = 0; bus.hcount = 0; bus.vcount = 0;
    #1;
    test_reset();
    test_basic();
    test_tick_hit();
    test_saturate();
    test_over();
    test_reset_mid();
    test_start_tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-state and score bookkeeping stage that sits directly upstream of the 3-digit score renderer. It drives the renderer's 8-bit score input.
- Collects hit/miss events from collision logic during a frame. Commits them to the visible score and lives only at a fixed vertical-blanking line, so the displayed digits never change mid-frame.
- Runs the IDLE / PLAYING / OVER game sequence and keeps a high score.

Parameters:
- VTICK, 480: vcount line on which the frame commit tick fires (first blanking line).
- LIVES, 3: lives loaded at game start (1..3).
- OVER_FRAMES, 120: frames spent in OVER before automatic return to IDLE (1..255).

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- pixpulse  in  1  pixel enable, asserted every 4 clocks
- hcount  in  10  current x pixel
- vcount  in  10  current y line
- start  in  1  single-cycle start pulse from button conditioner
- hit  in  1  single-cycle hit event
- points  in  4  points for hit; sampled only when hit=1
- miss  in  1  single-cycle life-loss event
- score  out  8  committed score, to renderer
- high_score  out  8  best committed final score since reset
- lives  out  2  committed lives remaining
- playing  out  1  high in PLAYING
- game_over  out  1  high in OVER

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, score=0, high_score=0, lives=0, pending_pts=0, pending_miss=0, over_cnt=0, playing=0, game_over=0. Reset mid-game discards all pending events.
- Frame tick: tick = pixpulse & (hcount==0) & (vcount==VTICK). This is exactly one clk cycle per frame.
- All outputs are registered. Committed values appear on the clk edge ending the tick cycle and hold until the next tick.
- IDLE:
  - score, lives and high_score hold; hit/miss ignored.
  - start=1 -> PLAYING; score<=0, lives<=LIVES, pending cleared.
  - tick has no effect.
- PLAYING:
  - hit=1 (non-tick cycle): pending_pts <= min(pending_pts+points, 255). points=0 adds nothing.
  - miss=1 (non-tick cycle): pending_miss <= min(pending_miss+1, 3).
  - hit and miss in the same cycle: both accumulate.
  - tick cycle:
    - score <= min(score+pending_pts, 255) (9-bit sum, saturate).
    - lives <= (pending_miss >= lives) ? 0 : lives-pending_miss.
    - Pending registers are reloaded with this cycle's own hit/miss contribution only. An event coincident with the tick lands in the next frame, not this one.
  - If the committed lives value is 0: -> OVER, over_cnt<=0. high_score <= max(high_score, new score), evaluated on the post-commit score.
  - start in PLAYING is ignored.
- OVER:
  - hit/miss ignored; pending held at 0.
  - Each tick: over_cnt++. When over_cnt reaches OVER_FRAMES-1 on a tick -> IDLE. Score and lives stay visible.
  - start=1 -> PLAYING immediately (same actions as from IDLE). start takes priority over a coincident tick.
- Score saturates at 255 and never wraps. The renderer shows it as 3 BCD digits.
- playing/game_over are decoded from the state register. They are never both 1.

Test Plan:
- rst then start, 3 hits of points=5 in one frame -> score stays 0 until tick; score=15 on the clk after tick; lives=3, playing=1.
- score=250, then hits totalling 12 points in one frame -> after tick score=255 (saturated, no wrap); a further hit with points=9 plus tick -> score stays 255.
- hit (points=7) asserted in the tick cycle itself -> score unchanged at that tick; score +7 at the following tick.
- Lives=3, 4 misses in one frame -> at tick lives=0, game_over=1, high_score=final score. After OVER_FRAMES ticks -> IDLE, game_over=0, score retained.
- In OVER, start together with tick -> PLAYING next clk, score=0, lives=3, high_score unchanged; next game ending with a lower score leaves high_score unchanged.
- rst asserted in PLAYING with pending_pts=20 -> next clk all outputs 0, state IDLE; following tick leaves score=0.
